// File: rtl/wall_follower.sv
`default_nettype none
// ============================================================================
// Module      : wall_follower
// Description : Right/left-hand wall-following maze walker driving an external
//               1-bit-per-cell maze memory (read strobe, visited-write strobe).
// Revision    : 1.0
// ============================================================================
module wall_follower #(
   parameter int MAZE_WIDTH = 6,
   parameter int STEP_W     = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [MAZE_WIDTH-1:0] starting_row,
   input  logic [MAZE_WIDTH-1:0] starting_col,
   input  logic [1:0]            start_dir,
   input  logic                  hand_sel,
   input  logic                  maze_in,
   output logic [MAZE_WIDTH-1:0] row,
   output logic [MAZE_WIDTH-1:0] col,
   output logic                  maze_oe,
   output logic                  maze_we,
   output logic                  done,
   output logic                  fail,
   output logic [STEP_W-1:0]     step_count
);
   localparam logic [MAZE_WIDTH-1:0] POS_MAX   = '1;
   localparam logic [MAZE_WIDTH-1:0] POS_ONE   = MAZE_WIDTH'(1);
   localparam logic [STEP_W-1:0]     MAX_STEPS = '1;
   localparam logic [STEP_W-1:0]     STEP_ONE  = STEP_W'(1);
   localparam logic [1:0]            DIR_S     = 2'd0;
   localparam logic [1:0]            DIR_E     = 2'd1;
   localparam logic [1:0]            DIR_N     = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_MARK, ST_SIDE_RD, ST_SIDE_EV,
      ST_FRONT_RD, ST_FRONT_EV, ST_DONE, ST_FAIL
   } state_t;

   state_t                  state, state_n;
   logic [MAZE_WIDTH-1:0]   cur_row, cur_row_n, cur_col, cur_col_n;
   logic [MAZE_WIDTH-1:0]   row_n, col_n;
   logic [1:0]              cur_dir, dir_n, turns, turns_n;
   logic                    hand, hand_n;
   logic                    maze_oe_n, maze_we_n, done_n, fail_n;
   logic [STEP_W-1:0]       step_n;

   function automatic logic nb_ok(input logic [MAZE_WIDTH-1:0] r,
                                  input logic [MAZE_WIDTH-1:0] c,
                                  input logic [1:0]            d);
      case (d)
         DIR_S:   nb_ok = (r != POS_MAX);
         DIR_E:   nb_ok = (c != POS_MAX);
         DIR_N:   nb_ok = (r != '0);
         default: nb_ok = (c != '0);
      endcase
   endfunction

   function automatic logic [MAZE_WIDTH-1:0] nb_row(input logic [MAZE_WIDTH-1:0] r,
                                                    input logic [1:0]            d);
      case (d)
         DIR_S:   nb_row = r + POS_ONE;
         DIR_N:   nb_row = r - POS_ONE;
         default: nb_row = r;
      endcase
   endfunction

   function automatic logic [MAZE_WIDTH-1:0] nb_col(input logic [MAZE_WIDTH-1:0] c,
                                                    input logic [1:0]            d);
      case (d)
         DIR_E:   nb_col = c + POS_ONE;
         DIR_N,
         DIR_S:   nb_col = c;
         default: nb_col = c - POS_ONE;
      endcase
   endfunction

   logic [1:0]            side_dir, away_dir;
   logic                  side_ok, front_ok, away_ok, on_border;
   logic [MAZE_WIDTH-1:0] side_row, side_col, front_row, front_col, away_row, away_col;

   assign side_dir  = hand ? cur_dir + 2'd1 : cur_dir - 2'd1;
   assign away_dir  = hand ? cur_dir - 2'd1 : cur_dir + 2'd1;
   assign side_ok   = nb_ok(cur_row, cur_col, side_dir);
   assign front_ok  = nb_ok(cur_row, cur_col, cur_dir);
   assign away_ok   = nb_ok(cur_row, cur_col, away_dir);
   assign side_row  = nb_row(cur_row, side_dir);
   assign side_col  = nb_col(cur_col, side_dir);
   assign front_row = nb_row(cur_row, cur_dir);
   assign front_col = nb_col(cur_col, cur_dir);
   assign away_row  = nb_row(cur_row, away_dir);
   assign away_col  = nb_col(cur_col, away_dir);
   assign on_border = (cur_row == '0) || (cur_row == POS_MAX) ||
                      (cur_col == '0) || (cur_col == POS_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cur_row    <= '0;
         cur_col    <= '0;
         cur_dir    <= DIR_S;
         hand       <= 1'b0;
         turns      <= '0;
         row        <= '0;
         col        <= '0;
         maze_oe    <= 1'b0;
         maze_we    <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         step_count <= '0;
      end else begin
         state      <= state_n;
         cur_row    <= cur_row_n;
         cur_col    <= cur_col_n;
         cur_dir    <= dir_n;
         hand       <= hand_n;
         turns      <= turns_n;
         row        <= row_n;
         col        <= col_n;
         maze_oe    <= maze_oe_n;
         maze_we    <= maze_we_n;
         done       <= done_n;
         fail       <= fail_n;
         step_count <= step_n;
      end
   end

   // Strobes and addresses are computed one state ahead so they are registered
   // in the cycle of the state that owns them.
   logic                  do_move, do_front, do_turn;
   logic [1:0]            mv_dir;
   logic [MAZE_WIDTH-1:0] mv_row, mv_col;

   always_comb begin
      state_n   = state;
      cur_row_n = cur_row;
      cur_col_n = cur_col;
      dir_n     = cur_dir;
      hand_n    = hand;
      turns_n   = turns;
      row_n     = row;
      col_n     = col;
      maze_oe_n = 1'b0;
      maze_we_n = 1'b0;
      done_n    = done;
      fail_n    = fail;
      step_n    = step_count;
      do_move   = 1'b0;
      do_front  = 1'b0;
      do_turn   = 1'b0;
      mv_dir    = cur_dir;
      mv_row    = front_row;
      mv_col    = front_col;

      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               state_n   = ST_MARK;
               cur_row_n = starting_row;
               cur_col_n = starting_col;
               dir_n     = start_dir;
               hand_n    = hand_sel;
               turns_n   = '0;
               step_n    = '0;
               done_n    = 1'b0;
               fail_n    = 1'b0;
               maze_we_n = 1'b1;
               row_n     = starting_row;
               col_n     = starting_col;
            end
         end
         ST_MARK: begin
            if ((step_count != '0) && on_border) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
            end else begin
               state_n = ST_SIDE_RD;
               if (side_ok) begin
                  maze_oe_n = 1'b1;
                  row_n     = side_row;
                  col_n     = side_col;
               end
            end
         end
         ST_SIDE_RD: begin
            if (side_ok) state_n = ST_SIDE_EV;
            else         do_front = 1'b1;
         end
         ST_SIDE_EV: begin
            if (!maze_in) begin
               do_move = 1'b1;
               mv_dir  = side_dir;
               mv_row  = side_row;
               mv_col  = side_col;
            end else begin
               do_front = 1'b1;
            end
         end
         ST_FRONT_RD: begin
            if (front_ok) state_n = ST_FRONT_EV;
            else          do_turn = 1'b1;
         end
         ST_FRONT_EV: begin
            if (!maze_in) do_move = 1'b1;
            else          do_turn = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase

      if (do_move) begin
         if (step_count == MAX_STEPS) begin
            state_n = ST_FAIL;
            fail_n  = 1'b1;
         end else begin
            state_n   = ST_MARK;
            dir_n     = mv_dir;
            cur_row_n = mv_row;
            cur_col_n = mv_col;
            step_n    = step_count + STEP_ONE;
            turns_n   = '0;
            maze_we_n = 1'b1;
            row_n     = mv_row;
            col_n     = mv_col;
         end
      end

      if (do_front) begin
         state_n = ST_FRONT_RD;
         if (front_ok) begin
            maze_oe_n = 1'b1;
            row_n     = front_row;
            col_n     = front_col;
         end
      end

      // Four walls in a row without a move means the walker is boxed in.
      if (do_turn) begin
         if (turns == 2'd3) begin
            state_n = ST_FAIL;
            fail_n  = 1'b1;
         end else begin
            state_n = ST_FRONT_RD;
            turns_n = turns + 2'd1;
            dir_n   = away_dir;
            if (away_ok) begin
               maze_oe_n = 1'b1;
               row_n     = away_row;
               col_n     = away_col;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_wall_follower.sv
`default_nettype none
// Bench for wall_follower: two instances (STEP_W 3 and 6) on an 8x8 maze,
// checked cycle by cycle against an algorithmic walk model.
module tb_wall_follower;
   localparam int MW = 3;
   localparam int N  = 8;

   typedef struct { bit oe; bit we; int r; int c; int steps; } rec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [MW-1:0] starting_row = '0;
   logic [MW-1:0] starting_col = '0;
   logic [1:0]    start_dir = '0;
   logic          hand_sel = 1'b0;
   logic          min_a = 1'b0, min_b = 1'b0;
   logic [MW-1:0] row_a, col_a, row_b, col_b;
   logic          oe_a, we_a, done_a, fail_a, oe_b, we_b, done_b, fail_b;
   logic [2:0]    step_a;
   logic [5:0]    step_b;

   bit   maze [N][N];
   rec_t mq[$], qa[$], qb[$];
   bit   m_done;
   int   m_steps;
   int   s_row, s_col, s_dir, s_hand;
   int   n_cmp = 0, n_bad = 0;
   bit   fin_done[2];
   int   fin_steps[2], oe_cnt[2], we_cnt[2], last_r[2], last_c[2], far_cnt[2];

   wall_follower #(.MAZE_WIDTH(MW), .STEP_W(3)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .starting_row(starting_row),
      .starting_col(starting_col), .start_dir(start_dir), .hand_sel(hand_sel),
      .maze_in(min_a), .row(row_a), .col(col_a), .maze_oe(oe_a), .maze_we(we_a),
      .done(done_a), .fail(fail_a), .step_count(step_a));

   wall_follower #(.MAZE_WIDTH(MW), .STEP_W(6)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .starting_row(starting_row),
      .starting_col(starting_col), .start_dir(start_dir), .hand_sel(hand_sel),
      .maze_in(min_b), .row(row_b), .col(col_b), .maze_oe(oe_b), .maze_we(we_b),
      .done(done_b), .fail(fail_b), .step_count(step_b));

   always #5 clk = ~clk;

   // Synchronous maze memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (oe_a) min_a <= maze[row_a][col_a];
      if (oe_b) min_b <= maze[row_b][col_b];
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input bit oe, input bit we, input int r, input int c, input int st);
      rec_t x;
      x.oe = oe; x.we = we; x.r = r; x.c = c; x.steps = st;
      mq.push_back(x);
   endtask

   task automatic nbr(input int r, input int c, input int d,
                      output int nr, output int nc, output bit ok);
      nr = r; nc = c;
      case (d)
         0:       nr = r + 1;
         1:       nc = c + 1;
         2:       nr = r - 1;
         default: nc = c - 1;
      endcase
      ok = (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
   endtask

   // Walk the maze by the hand rule and list what every cycle must show.
   task automatic model(input int maxs);
      int r, c, d, st, turns, nr, nc, sd;
      bit fin, moved, ok, free;
      mq.delete();
      r = s_row; c = s_col; d = s_dir; st = 0; fin = 0; m_done = 0;
      while (!fin) begin
         push(0, 1, r, c, st);
         if (st != 0 && (r == 0 || c == 0 || r == N-1 || c == N-1)) begin
            m_done = 1; fin = 1;
         end else begin
            moved = 0; turns = 0; free = 0;
            sd = s_hand ? (d + 1) % 4 : (d + 3) % 4;
            nbr(r, c, sd, nr, nc, ok);
            if (ok) begin push(1, 0, nr, nc, st); push(0, 0, 0, 0, st); free = !maze[nr][nc]; end
            else push(0, 0, 0, 0, st);
            if (free) begin
               if (st == maxs) fin = 1;
               else begin d = sd; r = nr; c = nc; st++; moved = 1; end
            end
            while (!fin && !moved) begin
               free = 0;
               nbr(r, c, d, nr, nc, ok);
               if (ok) begin push(1, 0, nr, nc, st); push(0, 0, 0, 0, st); free = !maze[nr][nc]; end
               else push(0, 0, 0, 0, st);
               if (free) begin
                  if (st == maxs) fin = 1;
                  else begin r = nr; c = nc; st++; moved = 1; end
               end else if (turns == 3) fin = 1;
               else begin turns++; d = s_hand ? (d + 3) % 4 : (d + 1) % 4; end
            end
         end
      end
      m_steps = st;
   endtask

   task automatic cmp_cycle(input int id);
      rec_t e;
      bit busy;
      string t;
      logic [31:0] oe, we, r, c, dn, fl, st;
      t = (id == 0) ? "A" : "B";
      if (id == 0) begin
         oe = 32'(oe_a); we = 32'(we_a); r = 32'(row_a); c = 32'(col_a);
         dn = 32'(done_a); fl = 32'(fail_a); st = 32'(step_a);
         busy = qa.size() > 0;
         if (busy) e = qa.pop_front();
      end else begin
         oe = 32'(oe_b); we = 32'(we_b); r = 32'(row_b); c = 32'(col_b);
         dn = 32'(done_b); fl = 32'(fail_b); st = 32'(step_b);
         busy = qb.size() > 0;
         if (busy) e = qb.pop_front();
      end
      if (busy) begin
         chk({t, " maze_oe"}, oe, 32'(e.oe));
         chk({t, " maze_we"}, we, 32'(e.we));
         if (e.oe || e.we) chk({t, " addr r*8+c"}, r * 8 + c, e.r * 8 + e.c);
         chk({t, " step_count"}, st, e.steps);
         chk({t, " done|fail while walking"}, dn | fl, 0);
      end else begin
         chk({t, " final done"}, dn, 32'(fin_done[id]));
         chk({t, " final fail"}, fl, 32'(!fin_done[id]));
         chk({t, " final strobes"}, oe | we, 0);
         chk({t, " final step_count"}, st, fin_steps[id]);
      end
      if (oe === 1) begin
         oe_cnt[id]++;
         if (r == N-1 || c == N-1) far_cnt[id]++;
      end
      if (we === 1) begin we_cnt[id]++; last_r[id] = r; last_c[id] = c; end
   endtask

   task automatic run_walk(input int r, input int c, input int d, input int h, input bit poke);
      int n;
      s_row = r; s_col = c; s_dir = d; s_hand = h;
      model(7);  qa = mq; fin_done[0] = m_done; fin_steps[0] = m_steps;
      model(63); qb = mq; fin_done[1] = m_done; fin_steps[1] = m_steps;
      for (int k = 0; k < 2; k++) begin
         oe_cnt[k] = 0; we_cnt[k] = 0; last_r[k] = -1; last_c[k] = -1; far_cnt[k] = 0;
      end
      n = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 3;
      @(negedge clk);
      start = 1'b1; starting_row = 3'(r); starting_col = 3'(c);
      start_dir = 2'(d); hand_sel = h[0];
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         cmp_cycle(0);
         cmp_cycle(1);
         if (poke && i == 3 && qa.size() > 0 && qb.size() > 0) begin
            start = 1'b1;
            starting_row = 3'($urandom_range(0, 7));
            starting_col = 3'($urandom_range(0, 7));
            start_dir = 2'($urandom_range(0, 3));
            hand_sel = ~hand_sel;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " A row/col"}, 32'({row_a, col_a}), 0);
      chk({nm, " A strobes"}, 32'({oe_a, we_a}), 0);
      chk({nm, " A done/fail"}, 32'({done_a, fail_a}), 0);
      chk({nm, " A step_count"}, 32'(step_a), 0);
      chk({nm, " B row/col"}, 32'({row_b, col_b}), 0);
      chk({nm, " B strobes"}, 32'({oe_b, we_b}), 0);
      chk({nm, " B done/fail"}, 32'({done_b, fail_b}), 0);
      chk({nm, " B step_count"}, 32'(step_b), 0);
   endtask

   task automatic fill(input bit v);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) maze[i][j] = v;
   endtask

   initial begin
      fill(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("idle");

      // Straight corridor down column 3
      for (int i = 0; i < N; i++) maze[i][3] = 1'b0;
      run_walk(0, 3, 0, 0, 1'b1);
      chk("corridor model steps", fin_steps[1], 7);
      chk("corridor A done", 32'(done_a), 1);
      chk("corridor A steps", 32'(step_a), 7);
      chk("corridor B we count", we_cnt[1], 8);
      chk("corridor B last we", last_r[1] * 8 + last_c[1], 7 * 8 + 3);

      // Reset in the middle of a walk, start held high throughout
      @(negedge clk);
      start = 1'b1; starting_row = 3'd0; starting_col = 3'd3; start_dir = 2'd0; hand_sel = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mid-walk side read", 32'({oe_b, row_b, col_b}), 32'({1'b1, 3'd0, 3'd2}));
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk_zero("rst edge1");
      @(negedge clk);
      chk_zero("rst edge2");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk_zero("after rst");

      // Boxed in
      fill(1'b1);
      run_walk(3, 3, 0, 0, 1'b0);
      chk("enclosed oe count", oe_cnt[1], 5);
      chk("enclosed we count", we_cnt[1], 1);
      chk("enclosed fail", 32'(fail_b), 1);
      chk("enclosed steps", 32'(step_b), 0);

      // T-junction
      fill(1'b1);
      for (int i = 4; i < N; i++) maze[i][4] = 1'b0;
      for (int j = 0; j < N; j++) maze[4][j] = 1'b0;
      run_walk(7, 4, 2, 0, 1'b1);
      chk("T right exit", last_r[1] * 8 + last_c[1], 4 * 8 + 7);
      chk("T right steps", 32'(step_b), 6);
      chk("T right done", 32'(done_b), 1);
      run_walk(7, 4, 2, 1, 1'b1);
      chk("T left exit", last_r[1] * 8 + last_c[1], 4 * 8 + 0);
      chk("T left steps A", 32'(step_a), 7);
      chk("T left done A", 32'(done_a), 1);

      // Border starts in an open field
      fill(1'b0);
      run_walk(0, 0, 0, 0, 1'b0);
      chk("border no wrapped read A", far_cnt[0], 0);
      chk("border no wrapped read B", far_cnt[1], 0);
      chk("border steps", 32'(step_b), 1);
      chk("border exit", last_r[1] * 8 + last_c[1], 1 * 8 + 0);
      run_walk(0, 0, 0, 1, 1'b0);
      chk("border left exit", last_r[1] * 8 + last_c[1], 0 * 8 + 1);
      run_walk(7, 7, 2, 0, 1'b0);

      // Closed ring: step limit
      fill(1'b1);
      for (int k = 2; k <= 5; k++) begin
         maze[2][k] = 1'b0; maze[5][k] = 1'b0; maze[k][2] = 1'b0; maze[k][5] = 1'b0;
      end
      run_walk(2, 2, 1, 0, 1'b1);
      chk("ring A fail", 32'(fail_a), 1);
      chk("ring A steps", 32'(step_a), 7);
      chk("ring A we count", we_cnt[0], 8);
      chk("ring B fail", 32'(fail_b), 1);
      chk("ring B steps", 32'(step_b), 63);

      // Random mazes, back-to-back starts from DONE/FAIL
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) maze[i][j] = ($urandom_range(0, 99) < 35);
         run_walk($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 1), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wall_follower.md
WALL_FOLLOWER -- requirements
Module: wall_follower

Interface
REQ-001 SHALL have parameter MAZE_WIDTH, default 6, meaning row/column address width; maze is 2^MAZE_WIDTH x 2^MAZE_WIDTH cells.
REQ-002 SHALL have parameter STEP_W, default 12, meaning step-counter width; MAX_STEPS = 2^STEP_W-1.
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse launching a walk; honoured only in IDLE, DONE or FAIL.
REQ-006 SHALL have ports starting_row, starting_col  in  MAZE_WIDTH  start cell; sampled on accepted start.
REQ-007 SHALL have port start_dir  in  2  initial heading: 0=S (row+1), 1=E (col+1), 2=N (row-1), 3=W (col-1); sampled on accepted start.
REQ-008 SHALL have port hand_sel  in  1  0=right-hand rule, 1=left-hand rule; sampled on accepted start.
REQ-009 SHALL have port maze_in  in  1  cell read data, 1=wall, 0=free; valid the cycle after maze_oe.
REQ-010 SHALL have ports row, col  out  MAZE_WIDTH  registered cell address.
REQ-011 SHALL have port maze_oe  out  1  registered read strobe for row/col.
REQ-012 SHALL have port maze_we  out  1  registered write strobe marking row/col as visited.
REQ-013 SHALL have port done  out  1  exit found; held high in DONE.
REQ-014 SHALL have port fail  out  1  walled in or step limit hit; held high in FAIL.
REQ-015 SHALL have port step_count  out  STEP_W  number of moves in the current walk.

Function
REQ-016 SHALL implement states IDLE, MARK, SIDE_RD, SIDE_EV, FRONT_RD, FRONT_EV, DONE, FAIL.
REQ-017 SHALL define side = dir-1 mod 4 (right hand) or dir+1 mod 4 (left hand); away = opposite rotation.
REQ-018 IDLE/DONE/FAIL: on start, latch position, heading and hand, clear step_count and turn counter, clear done/fail, go to MARK.
REQ-019 MARK: assert maze_we one cycle at current cell; if step_count!=0 and cell lies on border (row or col equal 0 or 2^MAZE_WIDTH-1), go to DONE, else go to SIDE_RD.
REQ-020 SIDE_RD: if side cell is in range, assert maze_oe with its address and go to SIDE_EV; if out of range, treat as wall without a read and go to FRONT_RD.
REQ-021 SIDE_EV: if maze_in=0, set heading=side, move to side cell, step_count+1, clear turn counter, go to MARK; else go to FRONT_RD.
REQ-022 FRONT_RD/FRONT_EV: same as REQ-020/REQ-021 for the cell ahead; if free, move ahead, step_count+1, clear turn counter, go to MARK.
REQ-023 FRONT_EV: if the front cell is a wall, set heading=away, increment turn counter, and go to FRONT_RD; on the 4th consecutive turn go to FAIL.
REQ-024 SHALL go to FAIL instead of moving when a move is required and step_count equals MAX_STEPS; step_count SHALL saturate, never wrap.
REQ-025 SHALL never issue addresses computed by wrap-around; out-of-range neighbours are walls.
REQ-026 maze_oe and maze_we SHALL never be high in the same cycle; both low in IDLE, DONE and FAIL.
REQ-027 SHALL ignore start outside IDLE, DONE and FAIL.
REQ-028 A start cell on the border SHALL NOT count as exit; only a border cell reached after at least 1 move counts.
REQ-029 Latency: each move costs 3 cycles through the side cell (MARK, SIDE_RD, SIDE_EV) or 5 cycles through the front cell.

Reset
REQ-030 On rst high at a clock edge: state=IDLE, row=col=0, maze_oe=maze_we=0, done=fail=0, step_count=0, heading=S, turn counter=0.
REQ-031 rst SHALL override start and any in-flight walk; no strobe asserted in the cycle after the reset edge.

Verification
REQ-032 Reset mid-walk: rst high 2 cycles during SIDE_EV -> next edge all outputs 0; start held high during rst ignored.
REQ-033 Corridor, MAZE_WIDTH=3: only column 3 free; start (0,3) dir S, right hand -> maze_we at (0,3)..(7,3); done=1; step_count=7.
REQ-034 Enclosed: start (3,3), four neighbours walls -> one maze_we pulse; four front reads; fail=1; step_count=0.
REQ-035 Hand select: T-junction with arms ending at (4,0) and (4,7); start (7,4) dir N -> hand_sel=0 exits at (4,7), hand_sel=1 exits at (4,0).
REQ-036 Border start: start (0,0) dir S -> no maze_oe on any wrapped address (e.g. col=7 or row=7 from a minus-one neighbour).
REQ-037 Step limit: STEP_W=3, closed loop path -> fail=1 with step_count=7; no eighth move and no wrap to 0.
